// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between instruction and data ports,
// with an in-order source-ID FIFO for response routing. Define OBI_ARB_STATS_EN for counters.
module obi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
`ifdef OBI_ARB_STATS_EN
  output logic [31:0]             instr_grant_cnt_o,
  output logic [31:0]             data_grant_cnt_o,
  output logic [31:0]             stall_cnt_o,
`endif
  output logic                    err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  logic [1:0]                 state_q, state_d;
  logic                       prio_q, prio_d;
  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       err_q, err_d;

  logic sel, req_raw, mem_req, grant, withdraw;
  logic fifo_empty, fifo_full, pop, can_push, head_id;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_MAX);
  assign pop        = mem_rvalid_i & ~fifo_empty;
  // A response retiring this cycle frees its slot for a grant in the same cycle.
  assign can_push   = ~fifo_full | pop;
  assign head_id    = ids_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sel      = SRC_I;
    req_raw  = 1'b0;
    withdraw = 1'b0;
    case (state_q)
      LOCK_I: begin
        sel = SRC_I;
        if (instr_req_i) req_raw = can_push;
        else             withdraw = 1'b1;
      end
      LOCK_D: begin
        sel = SRC_D;
        if (data_req_i) req_raw = can_push;
        else            withdraw = 1'b1;
      end
      default: begin
        state_d = IDLE;
        if (instr_req_i && data_req_i) sel = prio_q;
        else                           sel = data_req_i ? SRC_D : SRC_I;
        req_raw = (instr_req_i | data_req_i) & can_push;
      end
    endcase
    mem_req = req_raw & ~rst_i;
    grant   = mem_req & mem_gnt_i;
    if (grant || withdraw) state_d = IDLE;
    else if (mem_req)      state_d = (sel == SRC_D) ? LOCK_D : LOCK_I;
    prio_d = grant ? ~sel : prio_q;
  end

  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant) begin
      ids_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q | withdraw | (mem_rvalid_i & fifo_empty);
  end

  // NOTE: non-blocking assignments only, so every flop samples its pre-edge _d value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prio_q   <= SRC_I;
      // NOTE: the ID store is a few bits, so it is reset with the rest of the state.
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign mem_req_o   = mem_req;
  assign mem_addr_o  = !mem_req ? '0 : (sel == SRC_D) ? data_addr_i : instr_addr_i;
  assign mem_we_o    = mem_req & (sel == SRC_D) & data_we_i;
  assign mem_be_o    = !mem_req ? '0 : (sel == SRC_D) ? data_be_i : '1;
  assign mem_wdata_o = (mem_req && sel == SRC_D) ? data_wdata_i : '0;

  assign instr_gnt_o    = grant & (sel == SRC_I);
  assign data_gnt_o     = grant & (sel == SRC_D);
  assign instr_rvalid_o = pop & (head_id == SRC_I);
  assign data_rvalid_o  = pop & (head_id == SRC_D);
  assign instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
  assign data_rdata_o   = rst_i ? '0 : mem_rdata_i;
  assign err_o          = err_q;

`ifdef OBI_ARB_STATS_EN
  logic [31:0] instr_grant_cnt_q, instr_grant_cnt_d;
  logic [31:0] data_grant_cnt_q, data_grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    instr_grant_cnt_d = instr_grant_cnt_q;
    data_grant_cnt_d  = data_grant_cnt_q;
    stall_cnt_d       = stall_cnt_q;
    if (instr_gnt_o && instr_grant_cnt_q != '1) instr_grant_cnt_d = instr_grant_cnt_q + 32'd1;
    if (data_gnt_o && data_grant_cnt_q != '1)   data_grant_cnt_d  = data_grant_cnt_q + 32'd1;
    if (mem_req && !mem_gnt_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_grant_cnt_q <= '0;
      data_grant_cnt_q  <= '0;
      stall_cnt_q       <= '0;
    end else begin
      instr_grant_cnt_q <= instr_grant_cnt_d;
      data_grant_cnt_q  <= data_grant_cnt_d;
      stall_cnt_q       <= stall_cnt_d;
    end
  end

  assign instr_grant_cnt_o = instr_grant_cnt_q;
  assign data_grant_cnt_o  = data_grant_cnt_q;
  assign stall_cnt_o       = stall_cnt_q;
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: behavioural request/queue model plus an
// rvalid scoreboard monitor; directed scenarios followed by randomized traffic.
module tb_obi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i;
  logic [AW-1:0] instr_addr_i, data_addr_i;
  logic [DW/8-1:0] data_be_i;
  logic [DW-1:0] data_wdata_i, mem_rdata_i;
  logic          instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [DW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o;
  logic          mem_req_o, mem_we_o, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW/8-1:0] mem_be_o;
`ifdef OBI_ARB_STATS_EN
  logic [31:0]   instr_grant_cnt_o, data_grant_cnt_o, stall_cnt_o;
`endif

  obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
`ifdef OBI_ARB_STATS_EN
    .instr_grant_cnt_o(instr_grant_cnt_o), .data_grant_cnt_o(data_grant_cnt_o),
    .stall_cnt_o(stall_cnt_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: outstanding source IDs in issue order (0=instr, 1=data),
  // the side currently holding the port (-1 = none), and the last side granted.
  int          m_q[$];
  int          m_held;
  int          m_last;
  bit          m_err;
  int          m_stall, m_igr, m_dgr;
  logic [31:0] pend_rdata[$];
  logic [31:0] forced_rdata[$];

  typedef struct packed {
    logic        src;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Response monitor: every DUT rvalid must match the oldest expected response.
  always @(negedge clk_i) begin
    if (instr_rvalid_o === 1'b1 || data_rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_route", {instr_rvalid_o, data_rvalid_o}, mon_e.src ? 2'b01 : 2'b10);
        check("rdata", mon_e.src ? data_rdata_o : instr_rdata_o, mon_e.rdata);
      end
    end
  end

  // One clock cycle: drive at posedge+1, compare at negedge, then advance the model.
  task automatic step(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                      input logic [31:0] daddr, input bit dwe, input logic [3:0] dbe,
                      input logic [31:0] dwdata, input bit gnt, input bit rv,
                      output bit gi, output bit gd);
    int win;
    bit pop, room, drop, exp_req, exp_gnt;
    logic [31:0] rd;
    instr_req_i  = ireq;  instr_addr_i = iaddr;
    data_req_i   = dreq;  data_addr_i  = daddr;
    data_we_i    = dwe;   data_be_i    = dbe;  data_wdata_i = dwdata;
    mem_gnt_i    = gnt;   mem_rvalid_i = rv;
    mem_rdata_i  = (rv && pend_rdata.size() > 0) ? pend_rdata[0] : $urandom;

    pop  = rv && (m_q.size() > 0);
    room = (m_q.size() < MO) || pop;
    win  = -1;
    drop = 1'b0;
    if ((m_held == 0 && !ireq) || (m_held == 1 && !dreq)) drop = 1'b1;
    else if (m_held >= 0)   win = m_held;
    else if (ireq && dreq)  win = 1 - m_last;
    else if (ireq)          win = 0;
    else if (dreq)          win = 1;
    exp_req = (win >= 0) && room;
    exp_gnt = exp_req && gnt;

    @(negedge clk_i);
    check("mem_req_o", mem_req_o, exp_req);
    check("instr_gnt_o", instr_gnt_o, exp_gnt && win == 0);
    check("data_gnt_o", data_gnt_o, exp_gnt && win == 1);
    check("err_o", err_o, m_err);
    check("rvalid_any", instr_rvalid_o | data_rvalid_o, pop);
    if (exp_req) begin
      check("mem_addr_o", mem_addr_o, (win == 1) ? daddr : iaddr);
      check("mem_we_o", mem_we_o, (win == 1) ? dwe : 1'b0);
      check("mem_be_o", mem_be_o, (win == 1) ? dbe : 4'hF);
      if (win == 1) check("mem_wdata_o", mem_wdata_o, dwdata);
    end
`ifdef OBI_ARB_STATS_EN
    check("stall_cnt_o", stall_cnt_o, m_stall);
    check("instr_grant_cnt_o", instr_grant_cnt_o, m_igr);
    check("data_grant_cnt_o", data_grant_cnt_o, m_dgr);
`endif

    if (drop) begin
      m_err  = 1'b1;
      m_held = -1;
    end
    if (rv && m_q.size() == 0) m_err = 1'b1;
    if (pop) begin
      void'(m_q.pop_front());
      void'(pend_rdata.pop_front());
    end
    if (exp_req && !gnt) m_stall++;
    gi = exp_gnt && win == 0;
    gd = exp_gnt && win == 1;
    if (exp_gnt) begin
      m_q.push_back(win);
      m_last = win;
      m_held = -1;
      if (win == 0) m_igr++; else m_dgr++;
      rd = (forced_rdata.size() > 0) ? forced_rdata.pop_front() : $urandom;
      pend_rdata.push_back(rd);
      sb.push_back('{src: (win == 1), rdata: rd});
    end else if (exp_req) begin
      m_held = win;
    end
    @(posedge clk_i);
    #1;
  endtask

  bit gi_x, gd_x;

  task automatic idle(input bit gnt, input bit rv);
    step(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, '0, gnt, rv, gi_x, gd_x);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".mem_req_o"}, mem_req_o, 1'b0);
    check({tag, ".mem_addr_o"}, mem_addr_o, '0);
    check({tag, ".mem_we_o"}, mem_we_o, 1'b0);
    check({tag, ".mem_be_o"}, mem_be_o, '0);
    check({tag, ".mem_wdata_o"}, mem_wdata_o, '0);
    check({tag, ".instr_gnt_o"}, instr_gnt_o, 1'b0);
    check({tag, ".data_gnt_o"}, data_gnt_o, 1'b0);
    check({tag, ".instr_rvalid_o"}, instr_rvalid_o, 1'b0);
    check({tag, ".data_rvalid_o"}, data_rvalid_o, 1'b0);
    check({tag, ".instr_rdata_o"}, instr_rdata_o, '0);
    check({tag, ".data_rdata_o"}, data_rdata_o, '0);
    check({tag, ".err_o"}, err_o, 1'b0);
`ifdef OBI_ARB_STATS_EN
    check({tag, ".stall_cnt_o"}, stall_cnt_o, '0);
`endif
  endtask

  // Asserts reset with whatever inputs are currently driven, checks outputs at once.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    #1;
    check_outputs_zero(tag);
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    m_q.delete(); pend_rdata.delete(); sb.delete(); forced_rdata.delete();
    m_held = -1; m_last = 1; m_err = 1'b0;
    m_stall = 0; m_igr = 0; m_dgr = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ip, dp, dwe, gi, gd;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    rst_i = 1'b1;
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    instr_addr_i = '0; data_addr_i = '0; data_be_i = '0; data_wdata_i = '0;
    mem_rdata_i = 32'h1234_5678;
    do_reset("reset");

    // Simultaneous requests: instr wins the first tie, data the next.
    step(1, 32'h100, 1, 32'h200, 1, 4'h3, 32'hDEAD, 1, 0, gi_x, gd_x);
    step(1, 32'h104, 1, 32'h200, 1, 4'h3, 32'hDEAD, 1, 0, gi_x, gd_x);
    // FIFO full: no request; a retiring response frees a slot in the same cycle.
    step(1, 32'h104, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    step(1, 32'h104, 0, 32'h0, 0, 4'h0, 32'h0, 1, 1, gi_x, gd_x);
    idle(0, 1);
    idle(0, 1);

    // Data locked through three stalls while instr rises; instr follows.
    step(0, 32'h0, 1, 32'h300, 0, 4'hF, 32'h0, 0, 0, gi_x, gd_x);
    step(1, 32'h400, 1, 32'h300, 0, 4'hF, 32'h0, 0, 0, gi_x, gd_x);
    step(1, 32'h400, 1, 32'h300, 0, 4'hF, 32'h0, 0, 0, gi_x, gd_x);
    step(1, 32'h400, 1, 32'h300, 0, 4'hF, 32'h0, 1, 0, gi_x, gd_x);
    step(1, 32'h400, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    idle(0, 1);
    idle(0, 1);

    // I, D, I grants returning 0xA, 0xB, 0xC in order.
    forced_rdata.push_back(32'hA);
    forced_rdata.push_back(32'hB);
    forced_rdata.push_back(32'hC);
    step(1, 32'h10, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    step(0, 32'h0, 1, 32'h20, 1, 4'h5, 32'hCAFE, 1, 0, gi_x, gd_x);
    step(1, 32'h14, 0, 32'h0, 0, 4'h0, 32'h0, 1, 1, gi_x, gd_x);
    idle(0, 1);
    idle(0, 1);

    // Response with nothing outstanding: sticky error.
    idle(0, 1);
    repeat (3) idle(0, 0);
    check("err_sticky", err_o, 1'b1);
    do_reset("reset_err1");

    // Instruction request withdrawn while holding the port.
    step(1, 32'h500, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, gi_x, gd_x);
    step(0, 32'h500, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, gi_x, gd_x);
    idle(0, 0);
    check("err_withdraw", err_o, 1'b1);
    do_reset("reset_err2");

    // Reset with two outstanding, requests still driven.
    step(1, 32'h700, 1, 32'h800, 0, 4'hF, 32'h0, 1, 0, gi_x, gd_x);
    step(1, 32'h704, 1, 32'h800, 0, 4'hF, 32'h0, 1, 0, gi_x, gd_x);
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    mem_rdata_i = 32'hFFFF_FFFF;
    do_reset("reset_mid");
    idle(0, 1);
    step(1, 32'h900, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    step(1, 32'h904, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    step(1, 32'h908, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    do_reset("reset_stats");

    // Five stall cycles before the grant.
    repeat (5) step(1, 32'h600, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, gi_x, gd_x);
`ifdef OBI_ARB_STATS_EN
    check("stall_cnt_5", stall_cnt_o, 32'd5);
`endif
    step(1, 32'h600, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, gi_x, gd_x);
    idle(0, 1);
    do_reset("reset_rand");

    // Randomized legal traffic: a request stays up until the model grants it.
    ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dbe = '0; dwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15)); dwd = $urandom;
      end
      step(ip, ia, dp, da, dwe, dbe, dwd, $urandom_range(0, 9) < 6,
           (pend_rdata.size() > 0) && ($urandom_range(0, 1) == 1), gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    for (int n = 0; n < MO && pend_rdata.size() > 0; n++) idle(0, 1);
    idle(0, 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one OBI memory port between the core instruction port and the core data port. Sits between the core and the grant-stall/memory model in the testbench memory subsystem.
- Arbitrates requests round-robin and holds each arbitration decision until its grant arrives.
- Tracks outstanding transactions in an in-order ID FIFO so each mem rvalid/rdata returns to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- MAX_OUTSTANDING, 2, depth of the source-ID FIFO; legal range 1..8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- instr_req_i  in  1  instruction request
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  DATA_WIDTH  instruction read data
- data_req_i  in  1  data request
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  data write enable
- data_be_i  in  DATA_WIDTH/8  data byte enables
- data_wdata_i  in  DATA_WIDTH  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  DATA_WIDTH  data read data
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory read data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset:
  - Outputs: all outputs 0.
  - Internal: FSM=IDLE, FIFO empty, round-robin pointer=instr (instr wins the first tie), err_o cleared.
- FSM states:
  - IDLE: no selection held.
  - LOCK_I: instr selected, waiting for grant.
  - LOCK_D: data selected, waiting for grant.
- IDLE transitions:
  - Eligibility: a request is eligible only if the FIFO is not full.
  - Winner selection: if both requests are eligible, the winner is the side opposite the last-granted side. Otherwise any single eligible request wins.
  - Same-cycle drive: the winner's fields drive mem_* combinationally and mem_req_o=1 in the same cycle.
  - No grant: if mem_gnt_i=0, the FSM moves to LOCK_I or LOCK_D.
- LOCK_x:
  - mem_* is driven only from the selected requester; the other requester is ignored.
  - On mem_gnt_i=1, return to IDLE.
  - Guarantees address/data stability for the downstream grant-stall module.
- Grant path (combinational, zero-cycle):
  - selected_gnt_o = mem_req_o & mem_gnt_i; the other gnt_o=0.
  - On that grant edge, push the source ID (0=instr, 1=data) and flip the round-robin pointer.
- mem_req_o:
  - 0 when the FIFO is full, even if requests are pending.
  - In LOCK_x it is forced to 1 while the FIFO is not full.
- Request withdrawn in LOCK_x (OBI violation): set err_o, return to IDLE next cycle, mem_req_o=0 that cycle.
- Instruction-port fixed fields: mem_we_o=0 and mem_be_o=all-ones whenever instr is selected.
- Response routing:
  - mem_rvalid_i=1 pops the FIFO head, forwards rvalid to the head's port, and drives mem_rdata_i to both rdata outputs.
  - Non-selected rvalid_o stays 0.
  - Responses are in order only; the response may arrive one cycle after the grant at the earliest.
- FIFO:
  - Circular buffer with rd/wr pointers wrapping modulo MAX_OUTSTANDING, plus a count register of width clog2(MAX_OUTSTANDING+1).
  - Push and pop in the same cycle: count unchanged, both pointers advance; legal even when full.
  - mem_rvalid_i with FIFO empty: set err_o, no pop, both rvalid_o=0.
- err_o: sticky until reset.
- Reset mid-transaction: all state clears immediately (asynchronous); in-flight responses arriving after reset flag err_o.

Optional Feature:
- Macro: OBI_ARB_STATS_EN.
- Enabled:
  - Adds 32-bit counters, each saturating at 0xFFFFFFFF: instr_grant_cnt_o, data_grant_cnt_o, and stall_cnt_o (cycles with mem_req_o=1 & mem_gnt_i=0).
  - Counters reset to 0.
  - These three outputs are exported as extra ports.
- Disabled: counters and ports are absent; all other behaviour is identical.

Test Plan:
- Both reqs in the same cycle after reset, mem_gnt_i=1 -> instr granted in cycle 0; data granted in cycle 1, which also covers the round-robin alternation.
- Data selected with mem_gnt_i held 0 for 3 cycles while instr_req rises -> mem_addr_o stays data_addr_i; data_gnt_o pulses in cycle 4; instr is granted next.
- MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 with instr_req_i=1. One rvalid -> FIFO pops, that rvalid routes to the first requester, and a new grant is accepted in the same cycle.
- Interleaved I,D,I grants, then 3 rvalids with rdata 0xA,0xB,0xC -> instr_rvalid_o/0xA, data_rvalid_o/0xB, instr_rvalid_o/0xC.
- mem_rvalid_i with empty FIFO -> err_o=1 and stays 1 until rst_i; instr_req_i dropped in LOCK_I -> err_o=1.
- Reset asserted with 2 outstanding -> all outputs 0 immediately; FIFO empty after release. With OBI_ARB_STATS_EN: 5 stall cycles -> stall_cnt_o=5.
